// File: rtl/div_unit_if.sv
// Handshake and result bundle between the EXE stage and the iterative divider.
interface div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        kill;
    logic        div_running;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, op, a, b, kill,
        input  div_running, done, result
    );

    modport slave (
        input  start, op, a, b, kill,
        output div_running, done, result
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: 33 cycles start-to-done, 1 for /0 and overflow.
// No backpressure: div_running stalls the pipeline, kill aborts, done pulses for one cycle.
module div_unit (
    input  logic       clk,
    input  logic       nrst,
    div_unit_if.slave  dif
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q,  state_d;
    logic [5:0]  cnt_q,    cnt_d;
    logic [31:0] rem_q,    rem_d;
    logic [31:0] quo_q,    quo_d;
    logic [31:0] dvs_q,    dvs_d;
    logic        q_neg_q,  q_neg_d;
    logic        r_neg_q,  r_neg_d;
    logic        is_rem_q, is_rem_d;
    logic [31:0] result_q, result_d;
    logic        done_q,   done_d;

    logic        is_signed, a_neg, b_neg, div_zero, sgn_ovf, accept;
    logic [31:0] a_mag, b_mag;
    logic [32:0] prem_shift, prem_sub;
    logic        step_ok;
    logic [31:0] rem_next, quo_next, q_fix, r_fix;

    // Operand decode and one restoring step on the 33-bit partial remainder.
    always_comb begin
        is_signed  = ~dif.op[0];
        a_neg      = is_signed & dif.a[31];
        b_neg      = is_signed & dif.b[31];
        a_mag      = a_neg ? -dif.a : dif.a;
        b_mag      = b_neg ? -dif.b : dif.b;
        div_zero   = (dif.b == 32'h0);
        sgn_ovf    = is_signed && (dif.a == 32'h8000_0000) && (dif.b == 32'hFFFF_FFFF);
        accept     = (state_q == S_IDLE) && dif.start && !dif.kill;

        prem_shift = {rem_q, quo_q[31]};
        prem_sub   = prem_shift - {1'b0, dvs_q};
        step_ok    = ~prem_sub[32];
        rem_next   = step_ok ? prem_sub[31:0] : prem_shift[31:0];
        quo_next   = {quo_q[30:0], step_ok};
        q_fix      = q_neg_q ? -quo_next : quo_next;
        r_fix      = r_neg_q ? -rem_next : rem_next;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        is_rem_d = is_rem_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    is_rem_d = dif.op[1];
                    if (div_zero) begin
                        result_d = dif.op[1] ? dif.a : 32'hFFFF_FFFF;
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                    end else if (sgn_ovf) begin
                        result_d = dif.op[1] ? 32'h0 : 32'h8000_0000;
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                    end else begin
                        rem_d   = 32'h0;
                        quo_d   = a_mag;
                        dvs_d   = b_mag;
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
                        cnt_d   = 6'd0;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (dif.kill) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                    // Last step also applies the sign fix so result is ready with done.
                    if (cnt_q == 6'd31) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = is_rem_q ? r_fix : q_fix;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            rem_q    <= 32'h0;
            quo_q    <= 32'h0;
            dvs_q    <= 32'h0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            is_rem_q <= 1'b0;
            result_q <= 32'h0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            is_rem_q <= is_rem_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Busy must be visible in the start cycle itself so the pipeline stalls there.
    assign dif.div_running = nrst && (accept || (state_q == S_BUSY));
    assign dif.done        = done_q;
    assign dif.result      = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random ops against an arithmetic model.
module tb_div_unit;
    logic clk;
    logic nrst;
    int   n_checks;
    int   n_fail;

    div_unit_if dif ();

    div_unit dut (
        .clk  (clk),
        .nrst (nrst),
        .dif  (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        special;
    } vec_t;

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
        if (!op[0]) return op[1] ? sa % sb : sa / sb;
        return op[1] ? a % b : a / b;
    endfunction

    // Drives one operation starting next cycle and records what the DUT shows each cycle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold_start, output logic [31:0] res, output int done_cyc,
                         output int run_cnt, output int run_last);
        @(posedge clk); #1;
        dif.start = 1'b1; dif.op = op; dif.a = a; dif.b = b; dif.kill = 1'b0;
        done_cyc = -1; run_cnt = 0; run_last = -1; res = 32'hx;
        for (int k = 0; k < 60; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                if (hold_start) begin
                    dif.op = ~op; dif.a = $urandom; dif.b = $urandom;
                end else begin
                    dif.start = 1'b0;
                end
            end
            #3;
            if (dif.div_running) begin run_cnt++; run_last = k; end
            if (dif.done) begin done_cyc = k; res = dif.result; break; end
        end
        if (!hold_start) dif.start = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0; dif.start = 1'b0; dif.kill = 1'b0; dif.op = 2'b01; dif.a = 32'd100; dif.b = 32'd7;
        repeat (2) @(posedge clk);
        #1; dif.start = 1'b1;
        #3;
        n_checks++; if (dif.div_running !== 1'b0) begin n_fail++; $display("FAIL reset_running got=%b exp=0", dif.div_running); end
        n_checks++; if (dif.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", dif.done); end
        n_checks++; if (dif.result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=00000000", dif.result); end
        @(posedge clk); #1; nrst = 1'b1; dif.start = 1'b0;
        #3;
        n_checks++; if (dif.div_running !== 1'b0) begin n_fail++; $display("FAIL reset_idle_running got=%b exp=0", dif.div_running); end
        n_checks++; if (dif.done !== 1'b0) begin n_fail++; $display("FAIL reset_idle_done got=%b exp=0", dif.done); end
    endtask

    task automatic test_directed();
        vec_t        v [10];
        logic [31:0] res;
        int          dc, rc, rl, exp_lat;
        v = '{
            '{2'b01, 32'd100,        32'd7,        32'h0000_000E, 1'b0},
            '{2'b00, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 1'b0},
            '{2'b10, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF, 1'b0},
            '{2'b01, 32'd5,          32'd0,        32'hFFFF_FFFF, 1'b1},
            '{2'b11, 32'd5,          32'd0,        32'h0000_0005, 1'b1},
            '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1},
            '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1},
            '{2'b00, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFF, 1'b1},
            '{2'b10, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFB, 1'b1},
            '{2'b01, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 1'b0}
        };
        for (int i = 0; i < 10; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, 1'b0, res, dc, rc, rl);
            exp_lat = v[i].special ? 1 : 33;
            n_checks++; if (res !== v[i].exp) begin n_fail++; $display("FAIL directed[%0d]_result got=%h exp=%h", i, res, v[i].exp); end
            n_checks++; if (dc !== exp_lat) begin n_fail++; $display("FAIL directed[%0d]_done_cycle got=%0d exp=%0d", i, dc, exp_lat); end
            n_checks++; if (rc !== exp_lat || rl !== exp_lat - 1) begin n_fail++; $display("FAIL directed[%0d]_running got=%0d cycles last=%0d exp=%0d cycles last=%0d", i, rc, rl, exp_lat, exp_lat - 1); end
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, res, exp;
        int          dc, rc, rl, exp_lat, mode;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            mode = $urandom_range(0, 9);
            if (mode == 0) b = 32'h0;
            else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (mode <= 4) b = 32'($urandom_range(1, 15));
            else b = $urandom;
            exp = ref_div(op, a, b);
            exp_lat = (b == 32'h0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
            do_op(op, a, b, 1'b0, res, dc, rc, rl);
            n_checks++; if (res !== exp) begin n_fail++; $display("FAIL random[%0d] op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, res, exp); end
            n_checks++; if (dc !== exp_lat || rc !== exp_lat) begin n_fail++; $display("FAIL random[%0d]_timing done=%0d running=%0d exp=%0d", i, dc, rc, exp_lat); end
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] res;
        int          dc, rc, rl;
        do_op(2'b00, 32'hFFFF_FF9C, 32'd7, 1'b1, res, dc, rc, rl);
        n_checks++; if (res !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL hold_start_result got=%h exp=fffffff2", res); end
        n_checks++; if (dc !== 33) begin n_fail++; $display("FAIL hold_start_done_cycle got=%0d exp=33", dc); end
        @(posedge clk); #1; dif.start = 1'b0;
        #3;
        n_checks++; if (dif.div_running !== 1'b0 || dif.done !== 1'b0) begin n_fail++; $display("FAIL start_in_done_ignored running=%b done=%b exp 0/0", dif.div_running, dif.done); end
    endtask

    task automatic test_kill();
        logic [31:0] res;
        int          dc, rc, rl, ndone, nrun;
        do_op(2'b01, 32'd1000, 32'd10, 1'b0, res, dc, rc, rl);
        n_checks++; if (res !== 32'd100) begin n_fail++; $display("FAIL kill_pre_result got=%h exp=00000064", res); end
        @(posedge clk); #1;
        dif.start = 1'b1; dif.op = 2'b01; dif.a = 32'hFFFF_FFFF; dif.b = 32'd3; dif.kill = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            dif.start = 1'b0;
            dif.kill = (k == 11);
            if (k == 11) begin
                #3;
                n_checks++; if (dif.div_running !== 1'b1) begin n_fail++; $display("FAIL kill_step10_running got=%b exp=1", dif.div_running); end
            end
        end
        #3;
        n_checks++; if (dif.div_running !== 1'b0 || dif.done !== 1'b0) begin n_fail++; $display("FAIL kill_next_idle running=%b done=%b exp 0/0", dif.div_running, dif.done); end
        ndone = 0; nrun = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #4;
            if (dif.done) ndone++;
            if (dif.div_running) nrun++;
        end
        n_checks++; if (ndone !== 0 || nrun !== 0) begin n_fail++; $display("FAIL kill_no_done done_pulses=%0d running_cycles=%0d exp 0/0", ndone, nrun); end
        n_checks++; if (dif.result !== 32'd100) begin n_fail++; $display("FAIL kill_result_held got=%h exp=00000064", dif.result); end
        do_op(2'b01, 32'd9, 32'd3, 1'b0, res, dc, rc, rl);
        n_checks++; if (res !== 32'd3 || dc !== 33) begin n_fail++; $display("FAIL kill_followup result=%h done=%0d exp=00000003 at 33", res, dc); end
    endtask

    task automatic test_kill_with_start();
        logic [31:0] res;
        int          dc, rc, rl, ndone, nrun;
        @(posedge clk); #1;
        dif.start = 1'b1; dif.kill = 1'b1; dif.op = 2'b01; dif.a = 32'd50; dif.b = 32'd5;
        #3;
        n_checks++; if (dif.div_running !== 1'b0) begin n_fail++; $display("FAIL kill_start_running got=%b exp=0", dif.div_running); end
        ndone = 0; nrun = 0;
        for (int k = 0; k < 36; k++) begin
            @(posedge clk); #1; dif.start = 1'b0; dif.kill = 1'b0;
            #3;
            if (dif.done) ndone++;
            if (dif.div_running) nrun++;
        end
        n_checks++; if (ndone !== 0 || nrun !== 0) begin n_fail++; $display("FAIL kill_start_nothing done_pulses=%0d running_cycles=%0d exp 0/0", ndone, nrun); end
        n_checks++; if (dif.result !== 32'd3) begin n_fail++; $display("FAIL kill_start_result_held got=%h exp=00000003", dif.result); end
        do_op(2'b11, 32'd50, 32'd7, 1'b0, res, dc, rc, rl);
        n_checks++; if (res !== 32'd1 || dc !== 33) begin n_fail++; $display("FAIL kill_start_followup result=%h done=%0d exp=00000001 at 33", res, dc); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] res;
        int          dc, rc, rl;
        @(posedge clk); #1;
        dif.start = 1'b1; dif.op = 2'b01; dif.a = 32'hFFFF_FFFF; dif.b = 32'd7; dif.kill = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk); #1;
            dif.start = 1'b0;
            if (k == 21) nrst = 1'b0;
        end
        #3;
        n_checks++; if (dif.div_running !== 1'b0) begin n_fail++; $display("FAIL midreset_forced_running got=%b exp=0", dif.div_running); end
        @(posedge clk); #1; nrst = 1'b1;
        #3;
        n_checks++; if (dif.div_running !== 1'b0 || dif.done !== 1'b0) begin n_fail++; $display("FAIL midreset_idle running=%b done=%b exp 0/0", dif.div_running, dif.done); end
        n_checks++; if (dif.result !== 32'h0) begin n_fail++; $display("FAIL midreset_result got=%h exp=00000000", dif.result); end
        do_op(2'b00, 32'hFFFF_FF9C, 32'd7, 1'b0, res, dc, rc, rl);
        n_checks++; if (res !== 32'hFFFF_FFF2 || dc !== 33 || rc !== 33) begin n_fail++; $display("FAIL midreset_followup result=%h done=%0d running=%0d exp=fffffff2 at 33/33", res, dc, rc); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_kill();
        test_kill_with_start();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
